ghostbus_arb2: RTL
==================

// Module: ghostbus_arb2
// PURPOSE
//  Two-requester arbiter sharing one ghostbus host port (addr/data/we/re) between two masters,
//  e.g. a UART debug host and a local sequencer. Serialises transactions: one in flight at a time.
//  Round-robin grant; fixed-latency read return. Sits between the host masters and the
//  auto-decoded ghostbus register/RAM tree.
// PARAMETERS
//  AW      24  ghostbus address width
//  DW      32  ghostbus data width
//  RD_LAT   1  cycles from gb_re strobe to gb_din valid (>=1, <=15)
// PORTS
//  clk        in   1   single clock; all logic on rising edge
//  rst_n      in   1   synchronous, active-low reset
//  mN_addr    in   AW  requester N address (N = 0,1)
//  mN_wdata   in   DW  requester N write data
//  mN_we      in   1   1 = write, 0 = read; qualified by mN_valid
//  mN_valid   in   1   request present; may be retracted before mN_ready
//  mN_ready   out  1   request accepted this cycle (comb. from valids, state, pointer)
//  mN_rdata   out  DW  read data; 0 for write acks; held until next response to N
//  mN_rvalid  out  1   one-cycle completion pulse (reads and writes)
//  gb_addr    out  AW  ghostbus address (registered)
//  gb_dout    out  DW  ghostbus write data (registered)
//  gb_we      out  1   one-cycle write strobe
//  gb_re      out  1   one-cycle read strobe
//  gb_din     in   DW  ghostbus read data, valid RD_LAT cycles after gb_re
// BEHAVIOUR
//  Reset: state IDLE, ptr=0, all outputs 0 (gb_addr, gb_dout, mN_rdata cleared).
//  States: IDLE -> ISSUE -> (write) RESP | (read) WAIT -> RESP -> IDLE.
//  IDLE: if any mN_valid, grant per ptr (ptr=N wins tie); assert mN_ready same cycle;
//   latch addr/wdata/we/owner; ptr <= other master. No valid -> stay, ptr unchanged.
//  ISSUE (1 cycle): gb_we or gb_re high exactly this cycle; gb_addr/gb_dout already stable.
//  WAIT: counter loads RD_LAT-1, counts down; sample gb_din in cycle ISSUE+RD_LAT into rdata reg.
//  RESP (1 cycle): owner's mN_rvalid=1, mN_rdata updated; other master's outputs unchanged.
//  Latency (accept at T): write gb_we @T+1, rvalid @T+2; read gb_re @T+1, rvalid @T+2+RD_LAT.
//  Next accept no earlier than the cycle after RESP; mN_ready never high outside IDLE.
//  Only one mN_ready high per cycle; never both rvalids.
//  Valid retracted in IDLE before ready: no transaction, ptr unchanged.
//  Valid held continuously by both: strict alternation 0,1,0,1...
//  gb_addr/gb_dout hold last transaction values between transactions (strobes qualify them).
//  Reset asserted mid-transaction: abort, no rvalid, no further strobe, outputs to reset values.
// STRUCTURE
//  Shared include ghostbus_arb_defs.vh: state localparams (IDLE/ISSUE/WAIT/RESP, 2 bits).
//  Sub-module rr_pick2: 2-way round-robin picker (valid[1:0], ptr -> grant[1:0]), comb.
//  Top: FSM, latency counter, request/response registers.
// TESTING
//  1 m0 write addr 0x000010 data 0x1234 -> gb_we 1 cycle @T+1 addr 0x10 dout 0x1234; m0_rvalid @T+2, rdata 0.
//  2 m1 read addr 0x100, RD_LAT=3, model returns 0x42 -> gb_re @T+1; m1_rvalid @T+5, m1_rdata 0x42.
//  3 both valid from reset, 4 reads each -> grants 0,1,0,1...; no overlapping strobes.
//  4 m0 valid pulse for 1 cycle while m1 busy -> no m0 accept, ptr unchanged, no gb strobe for m0.
//  5 rst_n low during WAIT -> no rvalid, gb_re/gb_we 0, all outputs 0 next cycle.
//  6 random 1k mixed traffic vs ref memory model -> all reads match; one strobe per accept.

Source files
------------

// File: rtl/ghostbus_arb2_pkg.sv
// Shared types for the two-master ghostbus arbiter: FSM state encoding and
// the read-latency counter width.
package ghostbus_arb2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // RD_LAT is limited to 1..15, so the countdown fits in 4 bits.
  localparam int CNT_W = 4;

endpackage

// File: rtl/ghostbus_arb2_rr_pick2.sv
// Two-way round-robin picker: on a tie the master named by ptr wins,
// otherwise the single requester is granted.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/ghostbus_arb2.sv
// Round-robin arbiter sharing one ghostbus host port between two masters,
// one transaction in flight, fixed-latency read return.
module ghostbus_arb2
  import ghostbus_arb2_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  input  logic          m0_valid,
  output logic          m0_ready,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rvalid,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  input  logic          m1_valid,
  output logic          m1_ready,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rvalid,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_dout,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_din,
  output logic [1:0]    dbg_state
);

  // Handshake: a request transfers in the cycle where mN_valid && mN_ready.
  // mN_valid may drop at any time before that; ready is only offered in IDLE,
  // to at most one master, and the completion is a single mN_rvalid pulse.

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

  state_t           state, state_nxt;
  logic             ptr;
  logic [1:0]       grant;
  logic             owner;
  logic             req_we;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             sel_we;

  rr_pick2 u_pick (
    .valid ({m1_valid, m0_valid}),
    .ptr   (ptr),
    .grant (grant)
  );

  assign m0_ready  = rst_n && (state == ST_IDLE) && grant[0];
  assign m1_ready  = rst_n && (state == ST_IDLE) && grant[1];
  assign accept    = m0_ready || m1_ready;
  assign sel_we    = grant[1] ? m1_we : m0_we;
  assign m0_rvalid = (state == ST_RESP) && !owner;
  assign m1_rvalid = (state == ST_RESP) && owner;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = req_we ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= 1'b0;
      owner    <= 1'b0;
      req_we   <= 1'b0;
      cnt      <= '0;
      gb_addr  <= '0;
      gb_dout  <= '0;
      gb_we    <= 1'b0;
      gb_re    <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      gb_we <= 1'b0;
      gb_re <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner   <= grant[1];
            req_we  <= sel_we;
            gb_addr <= grant[1] ? m1_addr  : m0_addr;
            gb_dout <= grant[1] ? m1_wdata : m0_wdata;
            gb_we   <= sel_we;
            gb_re   <= !sel_we;
            ptr     <= grant[0];
          end
        end
        ST_ISSUE: begin
          cnt <= LAT_LOAD;
          // Write acks return zero data; the owner sees it during RESP.
          if (req_we) begin
            if (owner) m1_rdata <= '0;
            else       m0_rdata <= '0;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            if (owner) m1_rdata <= gb_din;
            else       m0_rdata <= gb_din;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
